// File: rtl/pll_drp_ctrl.sv
// rtl/pll_drp_ctrl.sv - PLL DRP read-modify-write sequencer with lock wait; PLL_DRP_READBACK_EN adds write verify
module pll_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_mask,
  input  logic [15:0] cfg_data,
  input  logic        cfg_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int MAX_TO = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW = $clog2(MAX_TO + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
    VFY_REQ,
    VFY_WAIT,
`endif
    WAIT_ENTRY,
    RELEASE,
    WAIT_LOCK,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      addr_q, addr_d;
  logic [15:0]     mask_q, mask_d;
  logic [15:0]     data_q, data_d;
  logic            last_q, last_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pll_rst_q, pll_rst_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            accept;
  logic            drdy_expired;
  logic            lock_expired;

  // Handshake and DRP strobes decode straight from the state, so each REQ state gives a one-cycle pulse
  always_comb begin
    cfg_ready = (state_q == IDLE) || (state_q == WAIT_ENTRY) || (state_q == ERR);
    busy      = (state_q != IDLE) && (state_q != ERR);
`ifdef PLL_DRP_READBACK_EN
    drp_den   = (state_q == RD_REQ) || (state_q == WR_REQ) || (state_q == VFY_REQ);
`else
    drp_den   = (state_q == RD_REQ) || (state_q == WR_REQ);
`endif
    drp_dwe   = (state_q == WR_REQ);
    accept    = cfg_valid && cfg_ready;
    drdy_expired = (cnt_q == DRDY_LAST);
    lock_expired = (cnt_q == LOCK_LAST);
  end

  assign drp_daddr = addr_q;
  assign drp_di    = wdata_q;
  assign pll_rst   = pll_rst_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign done      = done_q;

  // Next-state logic; drdy is checked before the timeout so a last-cycle response still succeeds
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    pll_rst_d  = pll_rst_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (accept) begin
          addr_d     = cfg_addr;
          mask_d     = cfg_mask;
          data_d     = cfg_data;
          last_d     = cfg_last;
          pll_rst_d  = 1'b1;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (drp_drdy) begin
          wdata_d = (drp_do & mask_q) | (data_q & ~mask_q);
          state_d = WR_REQ;
        end else if (drdy_expired) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = ERR;
        end
      end
      WR_REQ: state_d = WR_WAIT;
      WR_WAIT: begin
        if (drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
          state_d = VFY_REQ;
`else
          state_d = last_q ? RELEASE : WAIT_ENTRY;
`endif
        end else if (drdy_expired) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = ERR;
        end
      end
`ifdef PLL_DRP_READBACK_EN
      VFY_REQ: state_d = VFY_WAIT;
      VFY_WAIT: begin
        if (drp_drdy) begin
          if (drp_do != wdata_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
            state_d    = ERR;
          end else begin
            state_d = last_q ? RELEASE : WAIT_ENTRY;
          end
        end else if (drdy_expired) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = ERR;
        end
      end
`endif
      WAIT_ENTRY: begin
        if (accept) begin
          addr_d  = cfg_addr;
          mask_d  = cfg_mask;
          data_d  = cfg_data;
          last_d  = cfg_last;
          state_d = RD_REQ;
        end
      end
      RELEASE: begin
        pll_rst_d = 1'b0;
        state_d   = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (pll_locked) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (lock_expired) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
  end

  // State and datapath registers; reset abandons any sequence and releases the PLL
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      pll_rst_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      last_q     <= last_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      pll_rst_q  <= pll_rst_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb/tb_pll_drp_ctrl.sv - scoreboard bench for pll_drp_ctrl with DRP slave and PLL lock models
module tb_pll_drp_ctrl;

  localparam int DRDY_TO = 63;
  localparam int LOCK_TO = 100;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_mask = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_den, drp_dwe;
  logic        drp_drdy = 1'b0;
  logic        pll_rst;
  logic        pll_locked = 1'b0;

  always #5 clock = ~clock;

  pll_drp_ctrl #(.DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clock(clock), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'(i * 16'h0731) ^ 16'hA5C3;
    if (i == 8) v = 16'h1FFF;
    return v;
  endfunction

  // DRP slave: register file, configurable response latency, optional silence or corrupted readback
  logic [15:0] mem [128];
  bit          mem_init = 0;
  bit          pend = 0;
  int          pend_left = 0;
  logic [6:0]  pend_addr = '0;
  bit          pend_wr = 0;
  int          drp_lat = 2;
  bit          drdy_never = 0;
  bit          corrupt = 0;
  bit          lw_valid = 0;
  logic [6:0]  lw_addr = '0;

  always @(negedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] = init_val(i);
      mem_init = 1;
    end
    if (!corrupt) lw_valid = 0;
    drp_drdy = 1'b0;
    if (pend) begin
      if (pend_left <= 1) begin
        pend = 0;
        if (!drdy_never) begin
          drp_drdy = 1'b1;
          if (!pend_wr)
            drp_do = (corrupt && lw_valid && lw_addr == pend_addr) ? 16'h0000 : mem[pend_addr];
        end
      end else begin
        pend_left--;
      end
    end
    if (drp_den) begin
      pend      = 1;
      pend_left = drp_lat;
      pend_addr = drp_daddr;
      pend_wr   = drp_dwe;
      if (drp_dwe) begin
        mem[drp_daddr] = drp_di;
        lw_valid = 1;
        lw_addr  = drp_daddr;
      end
    end
  end

  // PLL model: LOCKED rises some cycles after reset release unless told never to lock
  int lock_delay = 3;
  bit lock_never = 0;
  int lk = 0;
  always @(negedge clock) begin
    if (pll_rst) begin
      pll_locked = 1'b0;
      lk = 0;
    end else if (!lock_never) begin
      lk++;
      if (lk >= lock_delay) pll_locked = 1'b1;
    end
  end

  // Reference model and scoreboard queues
  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] ref_mem [128];
  wr_t         exp_wr[$];
  int          exp_evt[$];   // 0 = done, 1..3 = error code

  // Monitor: every DRP access, done pulse and error rise is checked against the queues
  int         den_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int         den_cyc = 0, rst_fall_cyc = 0, err_cyc = 0;
  logic       err_prev = 1'b0, rst_prev = 1'b0;
  logic [6:0] last_rd_addr = '0;
  bit         rd_seen = 0;

  always @(negedge clock) begin
    if (drp_den) begin
      den_cnt++;
      den_cyc = cyc;
      check("cfg_ready_low_during_den", cfg_ready, 0);
      if (drp_dwe) begin
        wr_t w;
        wr_cnt++;
        check("pll_rst_high_during_write", pll_rst, 1);
        check("write_follows_read_same_addr", {rd_seen, last_rd_addr}, {1'b1, drp_daddr});
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          w = exp_wr.pop_front();
          check("write_addr", drp_daddr, w.a);
          check("write_data", drp_di, w.d);
        end
        rd_seen = 0;
      end else begin
        rd_seen = 1;
        last_rd_addr = drp_daddr;
      end
    end
    if (done) begin
      done_cnt++;
      check("busy_low_with_done", busy, 0);
      if (exp_evt.size() == 0) fail_now("unexpected_done");
      else check("event_done", 0, exp_evt.pop_front());
    end
    if (err && !err_prev) begin
      err_cyc = cyc;
      if (exp_evt.size() == 0) fail_now("unexpected_err");
      else check("event_err_code", err_code, exp_evt.pop_front());
    end
    if (!pll_rst && rst_prev) rst_fall_cyc = cyc;
    err_prev = err;
    rst_prev = pll_rst;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_drp_den"}, drp_den, 0);
    check({tag, "_drp_dwe"}, drp_dwe, 0);
    check({tag, "_drp_daddr"}, drp_daddr, 0);
    check({tag, "_drp_di"}, drp_di, 0);
    check({tag, "_pll_rst"}, pll_rst, 0);
  endtask

  task automatic send_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input bit last);
    int n = 0;
    @(negedge clock);
    cfg_addr  = a;
    cfg_mask  = m;
    cfg_data  = d;
    cfg_last  = last;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("accept_within_budget", n < 500, 1);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  // Expected write: kept bits come from the current register value, the rest from the new data
  task automatic add_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                           input bit last);
    wr_t w;
    w.a = a;
    w.d = (ref_mem[a] & m) | (d & ~m);
    ref_mem[a] = w.d;
    exp_wr.push_back(w);
    send_entry(a, m, d, last);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_evt.size() != 0 || exp_wr.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, exp_evt.size() + exp_wr.size(), 0);
  endtask

  task automatic run_seq(input int n, input int gap, input string name);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge clock);
      add_entry(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom), i == n - 1);
    end
    exp_evt.push_back(0);
    wait_drain(3000, name);
  endtask

  initial begin
    int w0, d0, den0, n, diff;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    // single entry: 0x1FFF with mask 0x1000, data 0x0041 must write 0x1041 once
    drp_lat = 2;
    w0 = wr_cnt;
    add_entry(7'h08, 16'h1000, 16'h0041, 1'b1);
    exp_evt.push_back(0);
    wait_drain(1000, "single_entry");
    check("single_entry_one_write", wr_cnt - w0, 1);
    check("single_entry_mem", mem[8], 16'h1041);

    // three entries spaced 10 cycles apart
    w0 = wr_cnt;
    run_seq(3, 10, "three_entries");
    check("three_entries_writes", wr_cnt - w0, 3);

    // randomized sequences
    for (int k = 0; k < 12; k++) begin
      drp_lat    = $urandom_range(1, 5);
      lock_delay = $urandom_range(2, 8);
      run_seq($urandom_range(1, 4), $urandom_range(0, 10), "random_seq");
    end
    drp_lat = 2;

    // DRP never answers: ERR with code 1 after DRDY_TO cycles of waiting
    drdy_never = 1;
    exp_evt.push_back(1);
    send_entry(7'h11, 16'hFFFF, 16'h0000, 1'b1);
    wait_drain(500, "drdy_timeout");
    check("drdy_timeout_latency", err_cyc - den_cyc, DRDY_TO + 1);
    check("drdy_timeout_pll_rst", pll_rst, 1);
    check("drdy_timeout_busy", busy, 0);
    check("drdy_timeout_ready", cfg_ready, 1);
    drdy_never = 0;

    // next accept clears the error and the sequence completes
    add_entry(7'h12, 16'h00FF, 16'hBEEF, 1'b1);
    check("err_cleared_on_accept", err, 0);
    check("err_code_cleared_on_accept", err_code, 0);
    exp_evt.push_back(0);
    wait_drain(1000, "after_err");

    // PLL never locks: ERR with code 2, PLL reset left released, no done
    lock_never = 1;
    d0 = done_cnt;
    add_entry(7'h20, 16'hF0F0, 16'h1234, 1'b1);
    exp_evt.push_back(2);
    wait_drain(1000, "lock_timeout");
    diff = err_cyc - rst_fall_cyc;
    check("lock_timeout_latency", (diff == LOCK_TO) || (diff == LOCK_TO + 1), 1);
    check("lock_timeout_pll_rst", pll_rst, 0);
    lock_never = 0;
    repeat (10) @(negedge clock);
    check("lock_timeout_no_done", done_cnt - d0, 0);

    // reset during WR_WAIT followed by a late drdy
    drp_lat = 6;
    w0 = wr_cnt;
    add_entry(7'h33, 16'h0F0F, 16'h5555, 1'b1);
    n = 0;
    while (wr_cnt == w0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("reset_test_write_seen", wr_cnt - w0, 1);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    den0 = den_cnt;
    d0   = done_cnt;
    repeat (20) @(negedge clock);
    check("mid_reset_no_den", den_cnt - den0, 0);
    check("mid_reset_no_done", done_cnt - d0, 0);
    check("mid_reset_idle_busy", busy, 0);
    drp_lat = 2;

    // corrupted readback after the write
    corrupt = 1;
    add_entry(7'h44, 16'h0000, 16'hC3C3, 1'b1);
`ifdef PLL_DRP_READBACK_EN
    exp_evt.push_back(3);
    wait_drain(1000, "corrupt_readback");
    check("corrupt_readback_pll_rst", pll_rst, 1);
`else
    exp_evt.push_back(0);
    wait_drain(1000, "corrupt_readback");
`endif
    corrupt = 0;

    repeat (5) @(negedge clock);
    check("final_queues_empty", exp_evt.size() + exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 SHALL have parameter DRDY_TIMEOUT, default 63, which sets the maximum number of cycles to wait for drp_drdy after a DEN pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, which sets the maximum number of cycles to wait for pll_locked after pll_rst release.
REQ-003 SHALL have these ports; the PLL's DCLK is driven from the same clock outside this block:
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config entry valid.
- cfg_ready  out  1  entry accepted when cfg_valid & cfg_ready.
- cfg_addr  in  7  DRP register address.
- cfg_mask  in  16  bit=1 keeps the current register bit.
- cfg_data  in  16  new bits, applied where mask=0.
- cfg_last  in  1  final entry of the sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful lock.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 DRDY timeout, 2 lock timeout, 3 readback mismatch.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_den  out  1  DRP enable.
- drp_dwe  out  1  DRP write enable.
- drp_drdy  in  1  DRP ready.
- pll_rst  out  1  PLL reset.
- pll_locked  in  1  PLL LOCKED.

Function
REQ-004 SHALL implement these FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VFY_REQ, VFY_WAIT, WAIT_ENTRY, RELEASE, WAIT_LOCK, ERR.
REQ-005 SHALL assert cfg_ready only in IDLE, WAIT_ENTRY and ERR.
REQ-006 On an accept in IDLE or ERR, SHALL latch the entry, assert pll_rst, clear err/err_code, assert busy, and enter RD_REQ the next cycle.
REQ-007 In RD_REQ, SHALL pulse drp_den for exactly one cycle with drp_dwe=0 and drp_daddr=latched address, then enter RD_WAIT.
REQ-008 In RD_WAIT, on drp_drdy SHALL capture drp_do and compute wdata=(drp_do & mask) | (data & ~mask), then enter WR_REQ.
REQ-009 In WR_REQ, SHALL pulse drp_den and drp_dwe together for one cycle with drp_di=wdata, then enter WR_WAIT.
REQ-010 In WR_WAIT, on drp_drdy SHALL go to VFY_REQ when the feature of REQ-021 is compiled in; otherwise to RELEASE if last, else WAIT_ENTRY.
REQ-011 In WAIT_ENTRY, an accept SHALL latch the entry and enter RD_REQ; pll_rst SHALL remain asserted while waiting, indefinitely.
REQ-012 RELEASE SHALL deassert pll_rst and enter WAIT_LOCK the next cycle.
REQ-013 In WAIT_LOCK, pll_locked high SHALL pulse done, drop busy, and return to IDLE; pll_locked SHALL be ignored in every other state.
REQ-014 Each wait state SHALL count cycles from zero on entry; reaching DRDY_TIMEOUT in RD_WAIT, WR_WAIT or VFY_WAIT SHALL enter ERR with err_code=1 and pll_rst held high.
REQ-015 Reaching LOCK_TIMEOUT in WAIT_LOCK SHALL enter ERR with err_code=2 and pll_rst low.
REQ-016 ERR SHALL hold err=1 and drop busy until the next accept.
REQ-017 drp_drdy arriving in any non-wait state SHALL be ignored; drp_drdy arriving on the same cycle as the timeout SHALL take priority as success.
REQ-018 drp_den SHALL never be asserted while a previous DRP access is outstanding.

Reset
REQ-019 resetn low SHALL asynchronously force IDLE and set these outputs: cfg_ready=1, busy=0, done=0, err=0, err_code=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, pll_rst=0; timeout counters SHALL clear.
REQ-020 resetn asserted mid-sequence SHALL abandon the sequence, releasing pll_rst with no DRP access pending; a late drp_drdy after reset SHALL be ignored.

Configuration
REQ-021 With macro PLL_DRP_READBACK_EN defined, VFY_REQ/VFY_WAIT SHALL re-read the address after each write, and any mismatch with wdata SHALL enter ERR with err_code=3 and pll_rst held high.
REQ-022 Without PLL_DRP_READBACK_EN, the VFY states SHALL be absent, and err_code=3 SHALL never be produced.

Verification
REQ-023 Single entry (addr 0x08, mask 0x1000, data 0x0041, last=1), DRP model returns 0x1FFF, drdy 2 cycles after den:
- drp_di=0x1041, written to 0x08, one write only.
- pll_rst released after the write; done pulses once when locked rises.
REQ-024 Three entries with cfg_valid gapped 10 cycles:
- pll_rst stays high throughout, with exactly 3 read/write pairs in order.
- cfg_ready is low during each DRP access.
REQ-025 DRP model never asserts drdy, DRDY_TIMEOUT=63:
- ERR after 63 cycles in RD_WAIT, err_code=1, pll_rst=1.
- The next accept clears err.
REQ-026 pll_locked held low, LOCK_TIMEOUT=100: err_code=2 after 100 cycles, pll_rst=0, done never pulses.
REQ-027 resetn pulsed low during WR_WAIT, then a late drp_drdy:
- All outputs return to reset values immediately.
- No further DEN and no done.
REQ-028 With PLL_DRP_READBACK_EN, model corrupts the readback to 0x0000: err_code=3; without the macro, the same run completes with done.
